// File: rtl/fibonacci_binary.sv
// fibonacci_binary: serial Zeckendorf-to-binary converter. It consumes one code bit per clock
// and generates the Fibonacci weights on the fly.
module fibonacci_binary #(
  parameter int FIB_W = 32,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             begin_f_b,
  input  logic [FIB_W-1:0] fibonacci_in,
  output logic             busy,
  output logic             convert_done,
  output logic [OUT_W-1:0] binary_out,
  output logic             not_canonical,
  output logic             out_of_range
);

  localparam int IDX_W = (FIB_W > 2) ? $clog2(FIB_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIB_W - 1);
  localparam logic [OUT_W-1:0] UPSTREAM_MAX = OUT_W'(65535);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [FIB_W-1:0] sr;
  logic [OUT_W-1:0] acc, fa, fb;
  logic [IDX_W-1:0] idx;
  logic             prev, nc;
  logic [OUT_W-1:0] acc_next;
  logic             nc_next;
  logic             last_step;

  // The result must include the bit consumed on the final step.
  assign acc_next  = acc + (sr[0] ? fa : '0);
  assign nc_next   = nc | (sr[0] & prev);
  assign last_step = (state == RUN) && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (begin_f_b) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    convert_done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr            <= '0;
      acc           <= '0;
      fa            <= '0;
      fb            <= '0;
      idx           <= '0;
      prev          <= 1'b0;
      nc            <= 1'b0;
      binary_out    <= '0;
      not_canonical <= 1'b0;
      out_of_range  <= 1'b0;
    end else begin
      if (state == IDLE && begin_f_b) begin
        sr   <= fibonacci_in;
        acc  <= '0;
        fa   <= OUT_W'(1);
        fb   <= OUT_W'(2);
        idx  <= '0;
        prev <= 1'b0;
        nc   <= 1'b0;
      end else if (state == RUN) begin
        acc  <= acc_next;
        nc   <= nc_next;
        prev <= sr[0];
        sr   <= sr >> 1;
        fa   <= fb;
        fb   <= fa + fb;
        idx  <= idx + 1'b1;
      end
      // Results are visible only from the done cycle onward.
      if (last_step) begin
        binary_out    <= acc_next;
        not_canonical <= nc_next;
        out_of_range  <= (acc_next > UPSTREAM_MAX);
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_binary.sv
// tb_fibonacci_binary: scenario tasks against an arithmetic Zeckendorf model,
// including a loopback through a greedy binary->Fibonacci encoder.
module tb_fibonacci_binary;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        begin_f_b = 1'b0;
  logic [31:0] fibonacci_in = '0;
  logic        busy, convert_done, not_canonical, out_of_range;
  logic [31:0] binary_out;

  int passed = 0;
  int total  = 0;

  fibonacci_binary #(.FIB_W(32), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .begin_f_b(begin_f_b), .fibonacci_in(fibonacci_in),
    .busy(busy), .convert_done(convert_done), .binary_out(binary_out),
    .not_canonical(not_canonical), .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  // Weight of code bit i is F(i+2), with F(1)=F(2)=1.
  function automatic longint fib_weight(input int i);
    longint a = 1, b = 2, t;
    for (int k = 0; k < i; k++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  function automatic longint model_value(input logic [31:0] code);
    longint s = 0;
    for (int i = 0; i < 32; i++) if (code[i]) s += fib_weight(i);
    return s;
  endfunction

  function automatic logic model_nc(input logic [31:0] code);
    return ((code & (code >> 1)) != 32'd0);
  endfunction

  // Greedy Zeckendorf encoder standing in for the upstream converter.
  function automatic logic [31:0] encode(input longint v);
    logic [31:0] c = '0;
    longint r = v;
    for (int i = 31; i >= 0; i--) begin
      if (fib_weight(i) <= r) begin
        c[i] = 1'b1;
        r -= fib_weight(i);
      end
    end
    return c;
  endfunction

  // Runs one conversion from IDLE; ends #1 after the edge that returns to IDLE.
  task automatic run_conv(input logic [31:0] code, input bit scramble,
                          output logic [31:0] res, output logic nc, output logic oor,
                          output int lat, output bit got, output logic pulse_low);
    begin_f_b = 1'b1;
    fibonacci_in = code;
    @(posedge clk); #1;
    begin_f_b = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      if (scramble) fibonacci_in = $urandom;
      @(posedge clk); #1;
      lat++;
      if (convert_done) got = 1;
    end
    res = binary_out; nc = not_canonical; oor = out_of_range;
    @(posedge clk); #1;
    pulse_low = !convert_done && !busy;
  endtask

  task automatic test_reset();
    #1;
    total++; if ({busy, convert_done, binary_out, not_canonical, out_of_range} !== '0)
      $display("[TB] FAIL reset_outputs busy=%b done=%b out=%0d nc=%b oor=%b, required all 0",
               busy, convert_done, binary_out, not_canonical, out_of_range);
    else passed++;
    begin_f_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_hold busy=%b, required 0", busy);
    else passed++;
    begin_f_b = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [31:0] codes [6] = '{32'h0, 32'h214, 32'h1, 32'h5, 32'h3, 32'h5555_5555};
    logic [31:0] vals  [6] = '{32'd0, 32'd100, 32'd1, 32'd4, 32'd3, 32'd3524577};
    logic        ncs   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        oors  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] res; logic nc, oor, low; int lat; bit got;
    for (int i = 0; i < 6; i++) begin
      run_conv(codes[i], 0, res, nc, oor, lat, got, low);
      total++; if (!got || res !== vals[i] || nc !== ncs[i] || oor !== oors[i])
        $display("[TB] FAIL vector code=%h got=%0b out=%0d nc=%b oor=%b, required out=%0d nc=%b oor=%b",
                 codes[i], got, res, nc, oor, vals[i], ncs[i], oors[i]);
      else passed++;
      total++; if (!low) $display("[TB] FAIL done_width code=%h done still high after 1 cycle", codes[i]);
      else passed++;
    end
  endtask

  task automatic test_latency();
    logic [31:0] code, res; logic nc, oor, low; int lat; bit got;
    code = encode(54321);
    run_conv(code, 1, res, nc, oor, lat, got, low);
    total++; if (lat !== 32 || !got) $display("[TB] FAIL latency got %0d edges, required 32", lat);
    else passed++;
    total++; if (res !== 32'd54321 || nc !== 1'b0)
      $display("[TB] FAIL input_change out=%0d nc=%b, required 54321 nc=0", res, nc);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b; logic [31:0] r1, r2; int c1, c2; bit g1, g2;
    a = encode(777); b = encode(4242);
    begin_f_b = 1'b1; fibonacci_in = a;
    @(posedge clk); #1;
    fibonacci_in = b;
    c1 = 0; g1 = 0;
    while (!g1 && c1 < 100) begin @(posedge clk); #1; c1++; if (convert_done) g1 = 1; end
    r1 = binary_out;
    c2 = 0; g2 = 0;
    while (!g2 && c2 < 100) begin @(posedge clk); #1; c2++; if (convert_done) g2 = 1; end
    r2 = binary_out;
    begin_f_b = 1'b0;
    @(posedge clk); #1;
    total++; if (!g1 || c1 !== 32 || r1 !== 32'd777)
      $display("[TB] FAIL b2b_first lat=%0d out=%0d, required lat=32 out=777", c1, r1);
    else passed++;
    total++; if (!g2 || c2 !== 34)
      $display("[TB] FAIL b2b_period got %0d cycles, required 34", c2);
    else passed++;
    total++; if (r2 !== 32'd4242)
      $display("[TB] FAIL b2b_second out=%0d, required 4242", r2);
    else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] res; logic nc, oor, low; int lat; bit got; bit seen;
    begin_f_b = 1'b1; fibonacci_in = encode(999);
    @(posedge clk); #1;
    begin_f_b = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    total++; if ({busy, convert_done, binary_out, not_canonical, out_of_range} !== '0)
      $display("[TB] FAIL abort_outputs busy=%b done=%b out=%0d nc=%b oor=%b, required all 0",
               busy, convert_done, binary_out, not_canonical, out_of_range);
    else passed++;
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (convert_done) seen = 1; end
    rst = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (convert_done || busy) seen = 1; end
    total++; if (seen) $display("[TB] FAIL abort_no_done activity seen after abort, required none");
    else passed++;
    run_conv(encode(31415), 0, res, nc, oor, lat, got, low);
    total++; if (!got || res !== 32'd31415)
      $display("[TB] FAIL restart out=%0d, required 31415", res);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] code, res; logic nc, oor, low; int lat; bit got; longint v, e;
    // Loopback of upstream-range values, including both range ends.
    for (int n = 0; n < 250; n++) begin
      v = (n == 0) ? 0 : (n == 1) ? 65535 : longint'($urandom_range(65535));
      run_conv(encode(v), 0, res, nc, oor, lat, got, low);
      total++; if (!got || res !== v[31:0] || nc !== 1'b0 || oor !== 1'b0)
        $display("[TB] FAIL loopback v=%0d out=%0d nc=%b oor=%b", v, res, nc, oor);
      else passed++;
    end
    // Arbitrary words, canonical or not.
    for (int n = 0; n < 60; n++) begin
      code = (n == 0) ? 32'hFFFF_FFFF : $urandom;
      e = model_value(code);
      run_conv(code, 0, res, nc, oor, lat, got, low);
      total++; if (!got || res !== e[31:0] || nc !== model_nc(code) || oor !== (e > 65535))
        $display("[TB] FAIL random code=%h out=%0d nc=%b oor=%b, required out=%0d nc=%b oor=%b",
                 code, res, nc, oor, e, model_nc(code), (e > 65535));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_latency();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
